// File: rtl/quadrant_selector.sv
// rtl/quadrant_selector.sv - debounced button cursor over a 2x2 quadrant grid
// Moves are deferred to frame_tick so the highlight never shifts mid-frame.
module quadrant_selector #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  output logic [2:0] cuadrante,
  output logic       sel_pulse,
  output logic [2:0] sel_cuadrante
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

  typedef enum logic [1:0] {NAV, HOLD, LOCKED} state_t;

  logic [4:0]       raw;
  logic [4:0]       sync1_q, sync2_q, stable_q, stable_prev_q, ev_q;
  logic [CNT_W-1:0] cnt_q [5];

  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      ev_q          <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      ev_q          <= stable_q & ~stable_prev_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Row toggle swaps top/bottom, column toggle swaps left/right.
  function automatic logic [2:0] row_toggle(input logic [2:0] c);
    case (c)
      3'b001:  return 3'b011;
      3'b011:  return 3'b001;
      3'b010:  return 3'b100;
      3'b100:  return 3'b010;
      default: return c;
    endcase
  endfunction

  function automatic logic [2:0] col_toggle(input logic [2:0] c);
    case (c)
      3'b001:  return 3'b010;
      3'b010:  return 3'b001;
      3'b011:  return 3'b100;
      3'b100:  return 3'b011;
      default: return c;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cuad_q, cuad_d;
  logic [2:0] sel_cuad_q, sel_cuad_d;
  logic       sel_pulse_q, sel_pulse_d;
  logic       row_pend_q, row_pend_d;
  logic       col_pend_q, col_pend_d;
  logic       row_ev, col_ev, row_mv, col_mv;
  logic [2:0] moved;

  always_comb begin
    state_d     = state_q;
    cuad_d      = cuad_q;
    sel_cuad_d  = sel_cuad_q;
    sel_pulse_d = 1'b0;
    row_pend_d  = row_pend_q;
    col_pend_d  = col_pend_q;
    row_ev      = ev_q[B_UP] | ev_q[B_DOWN];
    col_ev      = ev_q[B_LEFT] | ev_q[B_RIGHT];
    row_mv      = row_pend_q | row_ev;
    col_mv      = col_pend_q | col_ev;
    moved       = cuad_q;

    if (win) begin
      state_d    = LOCKED;
      cuad_d     = 3'b000;
      row_pend_d = 1'b0;
      col_pend_d = 1'b0;
    end else begin
      case (state_q)
        NAV: begin
          if (frame_tick) begin
            if (row_mv) moved = row_toggle(moved);
            if (col_mv) moved = col_toggle(moved);
            cuad_d     = moved;
            row_pend_d = 1'b0;
            col_pend_d = 1'b0;
          end else begin
            row_pend_d = row_mv;
            col_pend_d = col_mv;
          end
          if (ev_q[B_SEL]) begin
            sel_pulse_d = 1'b1;
            sel_cuad_d  = cuad_q;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          row_pend_d = 1'b0;
          col_pend_d = 1'b0;
          if (!stable_q[B_SEL]) state_d = NAV;
        end
        LOCKED: begin
          row_pend_d = 1'b0;
          col_pend_d = 1'b0;
          cuad_d     = 3'b001;
          state_d    = NAV;
        end
        default: state_d = NAV;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NAV;
      cuad_q      <= 3'b001;
      sel_cuad_q  <= 3'b000;
      sel_pulse_q <= 1'b0;
      row_pend_q  <= 1'b0;
      col_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cuad_q      <= cuad_d;
      sel_cuad_q  <= sel_cuad_d;
      sel_pulse_q <= sel_pulse_d;
      row_pend_q  <= row_pend_d;
      col_pend_q  <= col_pend_d;
    end
  end

  assign cuadrante     = cuad_q;
  assign sel_pulse     = sel_pulse_q;
  assign sel_cuadrante = sel_cuad_q;

endmodule
